// File: rtl/dmem_ctrl.sv
// dmem_ctrl: dual-port data memory, byte/half/word load-store on port 0, word reads on port 1,
// registered read data with valid/error strobes and an optional post-reset clear sweep.
module dmem_ctrl #(
  parameter int DEPTH = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [1:0]  size0,
  input  logic        uns0,
  input  logic [31:0] addr0,
  input  logic [31:0] wd0,
  output logic [31:0] rd0,
  output logic        rvalid0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic [31:0] rd1,
  output logic        rvalid1,
  output logic        err1,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx0, idx1;
  logic bad0, bad1, acc0, acc1, wr0;
  logic [3:0] be0;
  logic [31:0] wd_lane, sh0, ld0;
  always_comb begin
    state_nx = state;
    busy = state == CLEAR;
    if (state == CLEAR && cnt == AW'(DEPTH - 1)) state_nx = READY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (busy) cnt <= cnt + 1'b1;
    end
  always_comb begin
    idx0 = addr0[AW+1:2];
    idx1 = addr1[AW+1:2];
    bad0 = (|addr0[31:AW+2]) || size0 == 2'b11 || (size0 == 2'b01 && addr0[0]) ||
           (size0 == 2'b10 && addr0[1:0] != 2'b00);
    bad1 = (|addr1[31:AW+2]) || addr1[1:0] != 2'b00;
    acc0 = req0 && !busy;
    acc1 = req1 && !busy;
    wr0 = acc0 && we0 && !bad0;
    be0 = size0 == 2'b10 ? 4'hf : size0 == 2'b01 ? (addr0[1] ? 4'hc : 4'h3) : 4'b0001 << addr0[1:0];
    wd_lane = size0 == 2'b10 ? wd0 : size0 == 2'b01 ? {2{wd0[15:0]}} : {4{wd0[7:0]}};
    sh0 = mem[idx0] >> {addr0[1:0], 3'b000};
    ld0 = size0 == 2'b00 ? {{24{~uns0 & sh0[7]}}, sh0[7:0]} :
          size0 == 2'b01 ? {{16{~uns0 & sh0[15]}}, sh0[15:0]} : sh0;
  end
  // Storage has no reset; the clear sweep is the only way to zero it.
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= '0;
    else if (wr0)
      for (int b = 0; b < 4; b++)
        if (be0[b]) mem[idx0][8*b +: 8] <= wd_lane[8*b +: 8];
  // Port 1 samples the array before this edge's store lands: read-before-write.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd0 <= '0;
      rvalid0 <= 1'b0;
      err0 <= 1'b0;
      rd1 <= '0;
      rvalid1 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      rvalid0 <= acc0;
      err0 <= acc0 && bad0;
      if (acc0) rd0 <= (bad0 || we0) ? '0 : ld0;
      rvalid1 <= acc1;
      err1 <= acc1 && bad1;
      if (acc1) rd1 <= bad1 ? '0 : mem[idx1];
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table, corner sequences and randomized traffic against a byte-array model.
module tb_dmem_ctrl;
  localparam int DEPTH = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, we0 = 0, uns0 = 0, req1 = 0;
  logic [1:0] size0 = 0;
  logic [31:0] addr0 = 0, wd0 = 0, addr1 = 0;
  logic [31:0] rd0, rd1;
  logic rvalid0, err0, rvalid1, err1, busy;
  int tests = 0, fails = 0;
  logic [7:0] mb [4*DEPTH];

  dmem_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .req0(req0), .we0(we0), .size0(size0), .uns0(uns0),
    .addr0(addr0), .wd0(wd0), .rd0(rd0), .rvalid0(rvalid0), .err0(err0),
    .req1(req1), .addr1(addr1), .rd1(rd1), .rvalid1(rvalid1), .err1(err1), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wd;
    logic [31:0] exp_rd; logic exp_err;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] p0_exp(logic we, logic [1:0] sz, logic uns, int a);
    int n;
    longint v;
    if (sz == 2'd3 || a >= 4*DEPTH || a % (1 << sz) != 0) return {1'b1, 32'h0};
    if (we) return 33'h0;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v |= longint'(mb[a+i]) << (8*i);
    if (!uns && mb[a+n-1][7]) v -= longint'(1) << (8*n);
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [32:0] p1_exp(int a);
    logic [31:0] w;
    if (a >= 4*DEPTH || a % 4 != 0) return {1'b1, 32'h0};
    w = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    return {1'b0, w};
  endfunction

  task automatic model_wr(logic [1:0] sz, int a, logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < (1 << sz); i++) begin
      t = wd >> (8*i);
      mb[a+i] = t[7:0];
    end
  endtask

  task automatic check_reset_vals(string name);
    chk({name, " rd0"}, rd0, 0);
    chk({name, " rd1"}, rd1, 0);
    chk({name, " rvalid0"}, 32'(rvalid0), 0);
    chk({name, " rvalid1"}, 32'(rvalid1), 0);
    chk({name, " err0"}, 32'(err0), 0);
    chk({name, " err1"}, 32'(err1), 0);
    chk({name, " busy"}, 32'(busy), 1);
  endtask

  task automatic count_busy(string name);
    int n = 0;
    logic saw = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rvalid0 || rvalid1) saw = 1;
      if (!busy) begin
        n = i;
        break;
      end
    end
    req0 = 0; req1 = 0;
    chk({name, " busy cycles"}, n, DEPTH);
    chk({name, " rvalid while busy"}, 32'(saw), 0);
  endtask

  task automatic p0(logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] wd);
    req0 = 1; we0 = we; size0 = sz; uns0 = uns; addr0 = a; wd0 = wd;
    @(posedge clk); #1;
    req0 = 0;
  endtask

  task automatic p1_read_zero(string name);
    for (int w = 0; w < DEPTH; w++) begin
      req1 = 1; addr1 = 32'(4*w);
      @(posedge clk); #1;
      req1 = 0;
      chk($sformatf("%s word %0d", name, w), rd1, 0);
    end
  endtask

  initial begin
    vec_t v [20];
    logic [32:0] e0, e1;
    logic [31:0] exp_rd0, exp_rd1;
    v[0]  = '{1, 2'd2, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0};
    v[1]  = '{1, 2'd0, 0, 32'h09, 32'h00000011, 32'h0, 0};
    v[2]  = '{0, 2'd2, 0, 32'h08, 32'h0, 32'hDEAD11EF, 0};
    v[3]  = '{0, 2'd1, 0, 32'h0A, 32'h0, 32'hFFFFDEAD, 0};
    v[4]  = '{0, 2'd0, 1, 32'h0B, 32'h0, 32'h000000DE, 0};
    v[5]  = '{0, 2'd0, 0, 32'h08, 32'h0, 32'hFFFFFFEF, 0};
    v[6]  = '{0, 2'd1, 1, 32'h08, 32'h0, 32'h000011EF, 0};
    v[7]  = '{0, 2'd2, 0, 32'h06, 32'h0, 32'h0, 1};
    v[8]  = '{0, 2'd1, 0, 32'h03, 32'h0, 32'h0, 1};
    v[9]  = '{0, 2'd3, 0, 32'h08, 32'h0, 32'h0, 1};
    v[10] = '{0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1};
    v[11] = '{1, 2'd2, 0, 32'h06, 32'hFFFFFFFF, 32'h0, 1};
    v[12] = '{1, 2'd1, 0, 32'h40, 32'hFFFFFFFF, 32'h0, 1};
    v[13] = '{1, 2'd3, 0, 32'h08, 32'hFFFFFFFF, 32'h0, 1};
    v[14] = '{0, 2'd2, 0, 32'h04, 32'h0, 32'h0, 0};
    v[15] = '{0, 2'd2, 0, 32'h08, 32'h0, 32'hDEAD11EF, 0};
    v[16] = '{1, 2'd1, 0, 32'h0E, 32'hA5A58001, 32'h0, 0};
    v[17] = '{0, 2'd2, 0, 32'h0C, 32'h0, 32'h80010000, 0};
    v[18] = '{0, 2'd1, 0, 32'h0E, 32'h0, 32'hFFFF8001, 0};
    v[19] = '{0, 2'd2, 0, 32'h3C, 32'h0, 32'h0, 0};
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h0;

    #2;
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 0;
    req0 = 1; we0 = 0; size0 = 2'd2; addr0 = 0; req1 = 1; addr1 = 0;
    count_busy("clear");
    p1_read_zero("after clear");

    foreach (v[i]) begin
      p0(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wd);
      chk($sformatf("vec%0d rvalid0", i), 32'(rvalid0), 1);
      chk($sformatf("vec%0d err0", i), 32'(err0), 32'(v[i].exp_err));
      chk($sformatf("vec%0d rd0", i), rd0, v[i].exp_rd);
      if (v[i].we && !v[i].exp_err) model_wr(v[i].size, int'(v[i].addr), v[i].wd);
    end

    req0 = 1; we0 = 1; size0 = 2'd2; addr0 = 32'h3C; wd0 = 32'h12345678;
    req1 = 1; addr1 = 32'h3C;
    @(posedge clk); #1;
    req0 = 0;
    chk("same edge rvalid1", 32'(rvalid1), 1);
    chk("same edge rd1 old", rd1, 0);
    model_wr(2'd2, 'h3C, 32'h12345678);
    @(posedge clk); #1;
    req1 = 0;
    chk("next edge rd1 new", rd1, 32'h12345678);
    @(posedge clk); #1;
    chk("idle rvalid1", 32'(rvalid1), 0);
    chk("idle rd1 hold", rd1, 32'h12345678);
    req1 = 1; addr1 = 32'h3E;
    @(posedge clk); #1;
    chk("p1 misaligned err1", 32'(err1), 1);
    chk("p1 misaligned rd1", rd1, 0);
    addr1 = 32'h40;
    @(posedge clk); #1;
    req1 = 0;
    chk("p1 range err1", 32'(err1), 1);
    chk("p1 range rvalid1", 32'(rvalid1), 1);

    exp_rd0 = rd0 === 32'hx ? 0 : 32'h0;
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    for (int it = 0; it < 400; it++) begin
      logic r0, r1, we, un;
      logic [1:0] sz;
      int a0, a1;
      logic [31:0] wd;
      r0 = $urandom_range(0, 3) != 0;
      r1 = $urandom_range(0, 1) == 1;
      we = $urandom_range(0, 1) == 1;
      un = $urandom_range(0, 1) == 1;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a0 = $urandom_range(0, 4*DEPTH + 15);
      if (sz != 2'd3 && $urandom_range(0, 1) == 1) a0 = a0 & ~((1 << sz) - 1);
      a1 = $urandom_range(0, 4*DEPTH + 7);
      if ($urandom_range(0, 2) != 0) a1 = a1 & ~3;
      wd = $urandom;
      e0 = p0_exp(we, sz, un, a0);
      e1 = p1_exp(a1);
      req0 = r0; we0 = we; size0 = sz; uns0 = un; addr0 = 32'(a0); wd0 = wd;
      req1 = r1; addr1 = 32'(a1);
      @(posedge clk); #1;
      if (r0 && we && !e0[32]) model_wr(sz, a0, wd);
      if (r0) exp_rd0 = e0[31:0];
      if (r1) exp_rd1 = e1[31:0];
      chk($sformatf("rand%0d rvalid0", it), 32'(rvalid0), 32'(r0));
      chk($sformatf("rand%0d err0", it), 32'(err0), 32'(r0 & e0[32]));
      chk($sformatf("rand%0d rd0", it), rd0, exp_rd0);
      chk($sformatf("rand%0d rvalid1", it), 32'(rvalid1), 32'(r1));
      chk($sformatf("rand%0d err1", it), 32'(err1), 32'(r1 & e1[32]));
      chk($sformatf("rand%0d rd1", it), rd1, exp_rd1);
    end
    req0 = 0; req1 = 0;

    reset = 1;
    #1;
    check_reset_vals("reset2");
    @(posedge clk); #1;
    reset = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid clear busy", 32'(busy), 1);
    reset = 1;
    #1;
    check_reset_vals("mid clear reset");
    @(posedge clk); #1;
    reset = 0;
    count_busy("restarted clear");
    p1_read_zero("after restarted clear");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
